// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-timing helper used by uart_rx and uart_tx
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int calc_rate_cnt(input int clk_fre, input int rate);
    return clk_fre * 1_000_000 / rate - 1;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bus; master = receiver (drives recv_valid/recv_data/recv_busy/recv_err), slave = consumer
interface uart_rx_if;
  logic       recv_valid;
  logic [7:0] recv_data;
  logic       recv_busy;
  logic       recv_err;
  modport master (output recv_valid, recv_data, recv_busy, recv_err);
  modport slave  (input  recv_valid, recv_data, recv_busy, recv_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: generic 2-flop synchronizer; ports clk, rst_n (async active-low), d (async in), q (synced out)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= {2{RESET_VAL}};
    else        {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit LSB-first UART receiver with mid-bit sampling; optional even parity via UART_RX_PARITY_EN
// Ports: clk, rst_n (async active-low), rx_pin (async serial in, idle high),
//        bus (uart_rx_if.master: recv_valid, recv_data, recv_busy, recv_err)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_pin,
  uart_rx_if.master       bus
);
  localparam int RATE_CNT = calc_rate_cnt(CLK_FRE, UART_RATE);
  localparam int HALF_CNT = RATE_CNT / 2;
  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_START  = 3'(START);
  localparam logic [2:0] S_DATA   = 3'(DATA);
  localparam logic [2:0] S_STOP   = 3'(STOP);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(PARITY);
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif
  logic [2:0]  state;
  logic [20:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_r;
  logic        rx_s, rx_s_d;
  logic        valid, err;
  logic [7:0]  data;
  logic        stop_ok;
  wire fall     = rx_s_d & ~rx_s;
  wire at_rate  = clk_cnt == 21'(RATE_CNT);
  wire at_half  = clk_cnt == 21'(HALF_CNT);
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx_pin), .q(rx_s));
`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign stop_ok = rx_s & ~par_err;
`else
  assign stop_ok = rx_s;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift_r <= '0;
      rx_s_d  <= 1'b1;
      valid   <= 1'b0;
      err     <= 1'b0;
      data    <= '0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      rx_s_d <= rx_s;
      valid  <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: if (fall) begin
          clk_cnt <= '0;
          state   <= S_START;
        end
        S_START: if (at_half) begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          state   <= rx_s ? S_IDLE : S_DATA;
        end else clk_cnt <= clk_cnt + 21'd1;
        S_DATA: if (at_rate) begin
          shift_r <= {rx_s, shift_r[7:1]};
          clk_cnt <= '0;
          bit_cnt <= bit_cnt + 3'd1;
          state   <= bit_cnt == 3'd7 ? S_AFTER_DATA : S_DATA;
        end else clk_cnt <= clk_cnt + 21'd1;
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (at_rate) begin
          par_err <= ^{shift_r, rx_s};
          clk_cnt <= '0;
          state   <= S_STOP;
        end else clk_cnt <= clk_cnt + 21'd1;
`endif
        S_STOP: if (at_rate) begin
          // returning at mid-stop-bit leaves half a bit to catch a back-to-back start edge
          valid   <= stop_ok;
          err     <= ~stop_ok;
          data    <= stop_ok ? shift_r : data;
          clk_cnt <= '0;
          state   <= S_IDLE;
        end else clk_cnt <= clk_cnt + 21'd1;
        default: state <= S_IDLE;
      endcase
    end
  assign bus.recv_valid = valid;
  assign bus.recv_err   = err;
  assign bus.recv_data  = data;
  assign bus.recv_busy  = state != S_IDLE;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8 data bits, 1 stop bit, no parity by default, LSB first.
- Pairs with the existing uart_tx.
- Sits between the board rx pin and consumer logic, such as the command parser or the sensor report path.
- Oversamples the line with the system clock, validates the start bit at mid-bit, samples each bit at mid-bit, and presents each byte with a one-cycle valid strobe.

Parameters:
- CLK_FRE, 50, system clock frequency in MHz.
- UART_RATE, 115200, baud rate in bit/s.
- Derived localparam RATE_CNT = CLK_FRE*1_000_000/UART_RATE - 1. This is the last count of one bit period.
- Derived localparam HALF_CNT = RATE_CNT/2, integer division.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_pin  in  1  serial input, asynchronous to clk, idle high.
- recv_valid  out  1  one-cycle pulse when recv_data holds a newly received byte.
- recv_data  out  8  last good byte; holds its value until the next good byte.
- recv_busy  out  1  high whenever the FSM is not in IDLE.
- recv_err  out  1  one-cycle pulse on a framing error (stop bit sampled low) or a parity error (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous) sets every output and register:
  - recv_valid=0, recv_err=0, recv_data=8'h00, recv_busy=0.
  - state=IDLE, all counters 0, shift register 0.
  - Synchronizer flops set to 1, so no false start is detected after reset.
- Reset asserted mid-frame aborts the frame. No valid or err pulse is produced. After release the block waits for a new falling edge.
- rx_pin passes through a 2-flop synchronizer giving rx_s. A third flop holds rx_s_d. Falling edge = rx_s_d==1 && rx_s==0.
- clk_cnt is 21 bits wide, counts 0..RATE_CNT and wraps to 0. bit_cnt is 3 bits wide.
- IDLE:
  - On a falling edge: clk_cnt<=0, go to START.
  - A line held low with no edge never triggers a new frame.
- START:
  - At clk_cnt==HALF_CNT, sample rx_s.
  - If 0: clk_cnt<=0, bit_cnt<=0, go to DATA.
  - If 1: treat as a glitch and go to IDLE with no pulse.
- DATA:
  - At clk_cnt==RATE_CNT (mid-bit), shift rx_s into shift_r at the MSB, shifting right, so the result is LSB-first.
  - On each sample: clk_cnt<=0, bit_cnt++.
  - After the sample taken with bit_cnt==7, go to STOP.
- STOP:
  - At clk_cnt==RATE_CNT, sample rx_s.
  - If 1: recv_data<=shift_r, recv_valid<=1 for exactly one cycle.
  - If 0: recv_err<=1 for one cycle, and recv_data is unchanged.
  - In both cases go to IDLE in the same cycle.
  - Returning at mid-stop-bit leaves half a bit of slack, so a back-to-back frame is caught.
- Latency from the falling edge at the pin to recv_valid:
  - 2 synchronizer cycles + 1 edge-detect cycle, plus
  - (HALF_CNT+1) + 9*(RATE_CNT+1) cycles, plus
  - 1 registered-output cycle.
- recv_valid and recv_err are never high in the same cycle.
- There is no back-pressure. The consumer must take recv_data within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at clk_cnt==RATE_CNT.
  - Even parity is required: XOR of the 8 data bits and the parity bit must equal 0.
  - On mismatch, at the stop sample recv_err pulses and recv_data is not updated, even if the stop bit is good.
  - Latency grows by RATE_CNT+1 cycles.
- Undefined: no PARITY state; the frame is 8N1. The recv_err port is still present and reports framing errors only.

Decomposition:
- Package uart_pkg:
  - State enum typedef: IDLE, START, DATA, PARITY, STOP; 3-bit encoding.
  - Function calc_rate_cnt(clk_fre, rate), shared with uart_tx so both ends compute bit timing identically.
- One sub-module: sync_2ff, a generic 2-flop synchronizer.
  - Parameter RESET_VAL, set to 1 here.
  - Reset input rst_n.
  - Reusable for other asynchronous pins.

Test Plan (CLK_FRE=50, UART_RATE=115200, so RATE_CNT=433 and HALF_CNT=216; driven by a bit-accurate 8N1 model):
- Send 8'h55 -> exactly one recv_valid pulse, recv_data==8'h55, recv_err never high. Pulse arrives 3 + 217 + 9*434 + 1 = 4127 cycles ±1 after the pin edge.
- Send 8'h00, 8'hFF, 8'hA3 back-to-back with zero idle between frames -> three valid pulses with data 00, FF, A3 in order; recv_busy drops for at most half a bit between frames.
- Low glitch of 100 cycles on an idle line -> no valid and no err; FSM back in IDLE within 220 cycles of the glitch start.
- Send 8'h3C with the stop bit forced low, then hold the line low -> one recv_err pulse, recv_data keeps its previous value, no new frame while the line stays low. A later good 8'h7E is received correctly.
- rst_n pulsed low during data bit 4 of 8'hC3 -> all outputs 0 asynchronously, no pulse for the aborted frame. A following 8'h81 is received correctly.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 1 -> valid, data 07. 8'h07 with parity bit 0 -> recv_err, no valid.
